// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states and fetch-unit constants.
package fetch_pkg;
    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_EXEC,
        FETCH_FAULT
    } fetch_state_t;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/instructions_pkg.sv
// instructions_pkg: decode-side selector for the next-PC source.
package instructions_pkg;
    typedef enum logic [0:0] {
        PC_INPUT_PC_PLUS_4,
        PC_INPUT_ALU
    } pc_input_sel_t;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, instruction-memory and decode handshake signals of the fetch unit.
interface pc_fetch_unit_if;
    instructions_pkg::pc_input_sel_t pc_input_sel;
    logic [31:0] alu_result;
    logic        pc_update;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus_4;
    logic        fetch_fault;
    modport master (
        input  pc_input_sel, alu_result, pc_update, imem_req_ready, imem_resp_valid,
               imem_resp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
               pc_plus_4, fetch_fault
    );
    modport slave (
        output pc_input_sel, alu_result, pc_update, imem_req_ready, imem_resp_valid,
               imem_resp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_out, instr_pc,
               pc_plus_4, fetch_fault
    );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: next-PC mux and jump-target alignment check.
module pc_next_calc
    import instructions_pkg::*;
(
    input  logic [31:0]   pc,
    input  pc_input_sel_t pc_input_sel,
    input  logic [31:0]   alu_result,
    output logic [31:0]   next_pc,
    output logic          misaligned
);
    assign next_pc    = pc_input_sel == PC_INPUT_ALU ? alu_result & ~32'h1 : pc + 32'd4;
    assign misaligned = pc_input_sel == PC_INPUT_ALU && alu_result[1];
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch with decode hand-off and sticky misaligned-target fault.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input logic             clk,
    input logic             reset,
    pc_fetch_unit_if.master bus
);
    fetch_state_t state, state_next;
    logic [31:0] pc, next_pc, instr_out, instr_pc;
    logic        misaligned, capture, load_pc, set_fault, fetch_fault;

    pc_next_calc u_next (
        .pc           (pc),
        .pc_input_sel (bus.pc_input_sel),
        .alu_result   (bus.alu_result),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk)
        state <= reset ? FETCH_REQ : state_next;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load_pc    = 1'b0;
        set_fault  = 1'b0;
        case (state)
            FETCH_REQ:  state_next = bus.imem_req_ready ? FETCH_WAIT : FETCH_REQ;
            FETCH_WAIT: begin
                capture    = bus.imem_resp_valid;
                state_next = bus.imem_resp_valid ? FETCH_HOLD : FETCH_WAIT;
            end
            FETCH_HOLD: state_next = bus.instr_ready ? FETCH_EXEC : FETCH_HOLD;
            FETCH_EXEC: begin
                load_pc    = bus.pc_update && !misaligned;
                set_fault  = bus.pc_update && misaligned;
                state_next = !bus.pc_update ? FETCH_EXEC : misaligned ? FETCH_FAULT : FETCH_REQ;
            end
            default:    state_next = FETCH_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            instr_out   <= NOP_INSTR;
            instr_pc    <= RESET_VECTOR;
            fetch_fault <= 1'b0;
        end else begin
            if (load_pc) pc <= next_pc;
            if (capture) begin
                instr_out <= bus.imem_resp_data;
                instr_pc  <= pc;
            end
            if (set_fault) fetch_fault <= 1'b1;
        end
    end

    // Request is suppressed while reset is held so memory never sees a fetch in the reset cycle.
    assign bus.imem_req_valid = state == FETCH_REQ && !reset;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = state == FETCH_HOLD;
    assign bus.instr_out      = instr_out;
    assign bus.instr_pc       = instr_pc;
    assign bus.pc_plus_4      = instr_pc + 32'd4;
    assign bus.fetch_fault    = fetch_fault;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, directed corner sequences and randomized run against a transaction-level model.
module tb_pc_fetch_unit;
    import instructions_pkg::*;
    import fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;

    typedef struct {
        pc_input_sel_t sel;
        logic [31:0]   alu;
        logic [31:0]   exp_addr;
        logic          exp_fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl [9];

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic quiet;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.pc_update       = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        quiet();
        #1 chk1("rst_req_low", bus.imem_req_valid, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk32("rst_addr", bus.imem_req_addr, RV);
        chk1("rst_instr_valid", bus.instr_valid, 1'b0);
        chk32("rst_instr_out", bus.instr_out, 32'h0000_0013);
        chk32("rst_instr_pc", bus.instr_pc, RV);
        chk1("rst_fault", bus.fetch_fault, 1'b0);
        chk1("rst_req_valid", bus.imem_req_valid, 1'b1);
    endtask

    task automatic fetch_one(input logic [31:0] word, input int rq_d, input int rs_d, input int ir_d,
                             output logic [31:0] addr);
        int n = 0;
        while (!bus.imem_req_valid && n < 20) begin
            tick(); #1; n++;
        end
        chk1("req_wait", n < 20, 1'b1);
        addr = bus.imem_req_addr;
        repeat (rq_d) begin
            tick(); #1;
            chk1("req_hold_valid", bus.imem_req_valid, 1'b1);
            chk32("req_hold_addr", bus.imem_req_addr, addr);
        end
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = ~word;
        tick(); #1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        chk1("wait_req_low", bus.imem_req_valid, 1'b0);
        chk1("wait_no_instr", bus.instr_valid, 1'b0);
        repeat (rs_d) begin
            tick(); #1;
            chk1("wait_no_instr", bus.instr_valid, 1'b0);
        end
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word;
        tick(); #1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = $urandom;
        for (int i = 0; i <= ir_d; i++) begin
            chk1("hold_valid", bus.instr_valid, 1'b1);
            chk32("hold_instr", bus.instr_out, word);
            chk32("hold_pc", bus.instr_pc, addr);
            chk32("hold_pc4", bus.pc_plus_4, addr + 32'd4);
            if (i < ir_d) begin
                tick(); #1;
            end
        end
        bus.imem_resp_valid = 1'b0;
        bus.instr_ready     = 1'b1;
        tick(); #1;
        bus.instr_ready = 1'b0;
        chk1("exec_instr_low", bus.instr_valid, 1'b0);
        chk1("exec_req_low", bus.imem_req_valid, 1'b0);
    endtask

    task automatic do_update(input pc_input_sel_t sel, input logic [31:0] alu);
        bus.pc_update    = 1'b1;
        bus.pc_input_sel = sel;
        bus.alu_result   = alu;
        tick(); #1;
        bus.pc_update = 1'b0;
    endtask

    initial begin
        logic [31:0] addr, cur, exp_pc, exp_instr, exp_ipc;
        bit outstanding, holding, awaiting, faulted, req_phase;
        int fcnt;

        tbl[0] = '{PC_INPUT_PC_PLUS_4, 32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[1] = '{PC_INPUT_PC_PLUS_4, 32'hDEAD_BEEF, 32'h0000_0008, 1'b0};
        tbl[2] = '{PC_INPUT_PC_PLUS_4, 32'h0000_0000, 32'h0000_000C, 1'b0};
        tbl[3] = '{PC_INPUT_ALU,       32'h0000_0100, 32'h0000_0100, 1'b0};
        tbl[4] = '{PC_INPUT_ALU,       32'h0000_0205, 32'h0000_0204, 1'b0};
        tbl[5] = '{PC_INPUT_ALU,       32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
        tbl[6] = '{PC_INPUT_PC_PLUS_4, 32'h0000_0002, 32'h0000_0000, 1'b0};
        tbl[7] = '{PC_INPUT_ALU,       32'h0000_1001, 32'h0000_1000, 1'b0};
        tbl[8] = '{PC_INPUT_ALU,       32'h0000_0206, 32'h0000_1000, 1'b1};

        bus.pc_input_sel   = PC_INPUT_PC_PLUS_4;
        bus.alu_result     = '0;
        bus.imem_resp_data = '0;
        do_reset();

        cur = RV;
        foreach (tbl[k]) begin
            fetch_one($urandom, 0, 0, 0, addr);
            chk32("tbl_fetch_addr", addr, cur);
            do_update(tbl[k].sel, tbl[k].alu);
            chk1("tbl_fault", bus.fetch_fault, tbl[k].exp_fault);
            chk1("tbl_req_valid", bus.imem_req_valid, !tbl[k].exp_fault);
            chk32("tbl_next_addr", bus.imem_req_addr, tbl[k].exp_addr);
            cur = tbl[k].exp_addr;
        end

        repeat (6) begin
            bus.imem_req_ready  = 1'b1;
            bus.imem_resp_valid = 1'b1;
            bus.instr_ready     = 1'b1;
            bus.pc_update       = 1'b1;
            bus.pc_input_sel    = PC_INPUT_PC_PLUS_4;
            tick(); #1;
            chk1("fault_sticky", bus.fetch_fault, 1'b1);
            chk1("fault_req_low", bus.imem_req_valid, 1'b0);
            chk1("fault_instr_low", bus.instr_valid, 1'b0);
        end
        do_reset();

        fetch_one(32'hCAFE_0001, 5, 3, 4, addr);
        chk32("slow_addr", addr, RV);
        bus.imem_resp_valid = 1'b1;
        bus.instr_ready     = 1'b1;
        repeat (4) begin
            tick(); #1;
            chk1("one_delivery", bus.instr_valid, 1'b0);
            chk1("no_req_before_update", bus.imem_req_valid, 1'b0);
        end
        quiet();
        do_update(PC_INPUT_ALU, 32'h0000_0040);
        chk32("jump40", bus.imem_req_addr, 32'h0000_0040);

        bus.imem_req_ready = 1'b1;
        tick(); #1;
        bus.imem_req_ready = 1'b0;
        chk1("in_wait", bus.imem_req_valid, 1'b0);
        do_reset();

        fetch_one($urandom, 0, 0, 0, addr);
        do_update(PC_INPUT_ALU, 32'h0000_0080);
        bus.imem_req_ready = 1'b1;
        tick(); #1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'h1234_5678;
        tick(); #1;
        bus.imem_resp_valid = 1'b0;
        chk1("in_hold", bus.instr_valid, 1'b1);
        chk32("in_hold_pc", bus.instr_pc, 32'h0000_0080);
        do_reset();

        exp_pc = RV;
        outstanding = 0; holding = 0; awaiting = 0; faulted = 0; fcnt = 0;
        exp_instr = '0; exp_ipc = '0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset = (faulted && fcnt >= 4) || $urandom_range(0, 299) == 0;
            bus.imem_req_ready  = $urandom_range(0, 2) != 0;
            bus.imem_resp_valid = $urandom_range(0, 2) == 0;
            bus.imem_resp_data  = $urandom;
            bus.instr_ready     = $urandom_range(0, 2) == 0;
            bus.pc_update       = $urandom_range(0, 3) == 0;
            bus.pc_input_sel    = $urandom_range(0, 1) == 1 ? PC_INPUT_ALU : PC_INPUT_PC_PLUS_4;
            bus.alu_result      = $urandom;
            if ($urandom_range(0, 15) != 0) bus.alu_result[1] = 1'b0;
            #1;
            req_phase = !outstanding && !holding && !awaiting && !faulted;
            chk1("rnd_req_valid", bus.imem_req_valid, req_phase && !reset);
            if (req_phase) chk32("rnd_addr", bus.imem_req_addr, exp_pc);
            chk1("rnd_instr_valid", bus.instr_valid, holding);
            if (holding) begin
                chk32("rnd_instr", bus.instr_out, exp_instr);
                chk32("rnd_instr_pc", bus.instr_pc, exp_ipc);
                chk32("rnd_pc4", bus.pc_plus_4, exp_ipc + 32'd4);
            end
            chk1("rnd_fault", bus.fetch_fault, faulted);
            if (reset) begin
                exp_pc = RV;
                outstanding = 0; holding = 0; awaiting = 0; faulted = 0; fcnt = 0;
            end else if (faulted) begin
                fcnt++;
            end else if (outstanding) begin
                if (bus.imem_resp_valid) begin
                    outstanding = 0;
                    holding     = 1;
                    exp_instr   = bus.imem_resp_data;
                    exp_ipc     = exp_pc;
                end
            end else if (holding) begin
                if (bus.instr_ready) begin
                    holding  = 0;
                    awaiting = 1;
                end
            end else if (awaiting) begin
                if (bus.pc_update) begin
                    awaiting = 0;
                    if (bus.pc_input_sel == PC_INPUT_ALU && bus.alu_result[1]) faulted = 1;
                    else exp_pc = bus.pc_input_sel == PC_INPUT_ALU ? bus.alu_result & ~32'h1 : exp_pc + 32'd4;
                end
            end else if (bus.imem_req_ready) begin
                outstanding = 1;
            end
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
